gcd_lcm_unit: RTL and testbench

GCD_LCM_UNIT -- requirements
Module: gcd_lcm_unit

---
 rtl/gcd_lcm_unit_if.sv | 24 ++
 rtl/gcd_lcm_unit.sv | 190 +++++++++++++++++++
 tb/tb_gcd_lcm_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_lcm_unit_if.sv
// Request/response bundle between the execute stage and the gcd/lcm unit.
// The stage drives Start, OpLcm and the operands. The unit returns Busy (stall), Done, Result and Overflow.
interface gcd_lcm_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             OpLcm;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Overflow;

    modport master (
        output Start, OpLcm, SrcA, SrcB,
        input  Busy, Done, Result, Overflow
    );

    modport slave (
        input  Start, OpLcm, SrcA, SrcB,
        output Busy, Done, Result, Overflow
    );
endinterface

// File: rtl/gcd_lcm_unit.sv
// Iterative gcd (subtractive) / lcm (additive) unit: Done comes RUN cycles + 1 edges after accept, or 1 edge for a zero operand.
// Busy stalls the pipeline and Start is ignored outside IDLE. Defining GCDLCM_TIMEOUT_EN adds a MAX_ITER iteration limit.
module gcd_lcm_unit #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 65535
) (
    input  logic           clk,
    input  logic           reset_n,
    gcd_lcm_unit_if.slave  io_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_mode_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_ovf_nxt;

    // One extra bit so a carry out of the multiple accumulators flags lcm overflow.
    logic [WIDTH:0]   w_sum_x;
    logic [WIDTH:0]   w_sum_y;
    logic             w_zero_op;

    assign w_sum_x   = {1'b0, r_x} + {1'b0, r_a};
    assign w_sum_y   = {1'b0, r_y} + {1'b0, r_b};
    assign w_zero_op = (io_if.SrcA == '0) || (io_if.SrcB == '0);

`ifdef GCDLCM_TIMEOUT_EN
    localparam logic [15:0] MAX_CNT = 16'(MAX_ITER);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 16'd1;
`else
    logic [15:0] w_unused_cfg;

    assign w_unused_cfg = 16'(MAX_ITER);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_mode_nxt   = r_mode;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
`ifdef GCDLCM_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
`endif

        unique case (r_state)
            S_IDLE: begin
                if (io_if.Start) begin
                    w_x_nxt    = io_if.SrcA;
                    w_y_nxt    = io_if.SrcB;
                    w_a_nxt    = io_if.SrcA;
                    w_b_nxt    = io_if.SrcB;
                    w_mode_nxt = io_if.OpLcm;
                    w_ovf_nxt  = 1'b0;
`ifdef GCDLCM_TIMEOUT_EN
                    w_cnt_nxt  = 16'd0;
`endif
                    if (w_zero_op) begin
                        // gcd with a zero operand is the other operand; lcm is zero.
                        if (io_if.OpLcm) begin
                            w_result_nxt = '0;
                        end else if (io_if.SrcA == '0) begin
                            w_result_nxt = io_if.SrcB;
                        end else begin
                            w_result_nxt = io_if.SrcA;
                        end
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
`ifdef GCDLCM_TIMEOUT_EN
                w_cnt_nxt = w_cnt_inc;
`endif
                if (r_x == r_y) begin
                    w_result_nxt = r_x;
                    w_state_nxt  = S_DONE;
                end else if (!r_mode) begin
                    if (r_x > r_y) begin
                        w_x_nxt = r_x - r_y;
                    end else begin
                        w_y_nxt = r_y - r_x;
                    end
                end else if (r_x < r_y) begin
                    if (w_sum_x[WIDTH]) begin
                        w_result_nxt = '0;
                        w_ovf_nxt    = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_x_nxt = w_sum_x[WIDTH-1:0];
                    end
                end else begin
                    if (w_sum_y[WIDTH]) begin
                        w_result_nxt = '0;
                        w_ovf_nxt    = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_y_nxt = w_sum_y[WIDTH-1:0];
                    end
                end
`ifdef GCDLCM_TIMEOUT_EN
                // A step that lands on equality still completes normally.
                if ((r_x != r_y) && (w_cnt_inc == MAX_CNT)) begin
                    w_result_nxt = '0;
                    w_ovf_nxt    = 1'b1;
                    w_state_nxt  = S_DONE;
                end
`endif
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
`ifdef GCDLCM_TIMEOUT_EN
            r_cnt    <= 16'd0;
`endif
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_mode   <= w_mode_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
`ifdef GCDLCM_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
`endif
        end
    end

    assign io_if.Busy     = (r_state == S_RUN);
    assign io_if.Done     = (r_state == S_DONE);
    assign io_if.Result   = r_result;
    assign io_if.Overflow = r_ovf;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Bench for gcd_lcm_unit: a directed vector table, hand sequences for overflow, ignored Start and mid-run reset,
// and random operations against an arithmetic gcd/lcm reference (build with GCDLCM_TIMEOUT_EN for the MAX_ITER=8 variant).
module tb_gcd_lcm_unit;

`ifdef GCDLCM_TIMEOUT_EN
    localparam int TB_MAX_ITER = 8;
`else
    localparam int TB_MAX_ITER = 65535;
`endif
    localparam int BUDGET = 3000;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    gcd_lcm_unit_if #(.WIDTH(32)) bus ();

    gcd_lcm_unit #(.WIDTH(32), .MAX_ITER(TB_MAX_ITER)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          ovf;
        longint      lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference from plain arithmetic: Euclid for gcd, lcm = a/g*b; the iteration count comes from
    // the sum of Euclid quotients (gcd) or the number of multiples visited (lcm).
    function automatic void model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ovf, output longint lat);
        longint x, y, t, qsum, g, l, steps;
        ovf = 1'b0;
        lat = 1;
        if (a == 0 || b == 0) begin
            r = op ? 32'd0 : ((a == 0) ? b : a);
            return;
        end
        x = longint'(a);
        y = longint'(b);
        qsum = 0;
        while (y != 0) begin
            qsum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        g = x;
        if (!op) begin
            r = g[31:0];
            steps = qsum;
        end else begin
            l = (longint'(a) / g) * longint'(b);
            if (l > 64'hFFFF_FFFF) begin
                r = 32'd0;
                ovf = 1'b1;
                steps = -1;
            end else begin
                r = l[31:0];
                steps = l / longint'(a) + l / longint'(b) - 1;
            end
        end
`ifdef GCDLCM_TIMEOUT_EN
        if (steps < 0 || steps > TB_MAX_ITER) begin
            r = 32'd0;
            ovf = 1'b1;
            steps = (steps < 0) ? -1 : TB_MAX_ITER;
        end
`endif
        lat = (steps < 0) ? -1 : steps + 1;
    endfunction

    // Issues one operation, then checks result, overflow, latency, Busy profile, Done pulse width and hold.
    task automatic check_op(input string name, input bit op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input bit exp_ovf, input longint exp_lat);
        longint      lat;
        bit          busy_hi, busy_lo;
        logic [31:0] res;
        bit          ovf;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.OpLcm = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        lat = 1;
        busy_hi = 1'b0;
        busy_lo = 1'b0;
        while (!bus.Done && lat < BUDGET) begin
            if (bus.Busy) busy_hi = 1'b1;
            else busy_lo = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " done_seen"}, 64'(bus.Done), 64'd1);
        res = bus.Result;
        ovf = bus.Overflow;
        chk({name, " result"}, 64'(res), 64'(exp_res));
        chk({name, " overflow"}, 64'(ovf), 64'(exp_ovf));
        if (exp_lat > 0) chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " busy_in_run"}, {62'd0, busy_hi, busy_lo}, (lat > 1) ? 64'd2 : 64'd0);
        chk({name, " busy_at_done"}, 64'(bus.Busy), 64'd0);
        @(posedge clk);
        #1;
        chk({name, " done_pulse"}, 64'(bus.Done), 64'd0);
        chk({name, " result_hold"}, {31'd0, bus.Overflow, bus.Result}, {31'd0, ovf, res});
    endtask

    initial begin
        logic [31:0] r;
        bit          o;
        longint      l;
        bit          op;
        logic [31:0] a, b;
        int          k;
        bit          done_seen;

        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bus.Start = 1'b0;
        bus.OpLcm = 1'b0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.Busy, bus.Done, bus.Overflow, bus.Result}, 35'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        vecs.push_back('{0, 32'd7,          32'd7,          32'd7,          0, 2});
        vecs.push_back('{0, 32'd12,         32'd18,         32'd6,          0, 4});
        vecs.push_back('{1, 32'd4,          32'd6,          32'd12,         0, 5});
        vecs.push_back('{0, 32'd0,          32'd9,          32'd9,          0, 1});
        vecs.push_back('{1, 32'd0,          32'd9,          32'd0,          0, 1});
        vecs.push_back('{0, 32'd0,          32'd0,          32'd0,          0, 1});
        vecs.push_back('{1, 32'd9,          32'd0,          32'd0,          0, 1});
        vecs.push_back('{0, 32'd35,         32'd14,         32'd7,          0, 5});
        vecs.push_back('{1, 32'd3,          32'd5,          32'd15,         0, 8});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 2});
        vecs.push_back('{1, 32'h0001_0000,  32'h0001_0000,  32'h0001_0000,  0, 2});
        vecs.push_back('{1, 32'h8000_0000,  32'h8000_0001,  32'd0,          1, 2});
`ifdef GCDLCM_TIMEOUT_EN
        vecs.push_back('{0, 32'd1,          32'd1000,       32'd0,          1, 9});
`else
        vecs.push_back('{0, 32'd1,          32'd1000,       32'd1,          0, 1001});
`endif

        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].ovf, vecs[i].lat);
        end

        // lcm overflow with Start held high (and new operands) through RUN and DONE.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.OpLcm = 1'b1;
        bus.SrcA  = 32'hFFFF_FFFF;
        bus.SrcB  = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        bus.OpLcm = 1'b0;
        bus.SrcA  = 32'd12;
        bus.SrcB  = 32'd18;
        k = 1;
        while (!bus.Done && k < BUDGET) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ovf_hold_start done", 64'(bus.Done), 64'd1);
        chk("ovf_hold_start result", 64'(bus.Result), 64'd0);
        chk("ovf_hold_start overflow", 64'(bus.Overflow), 64'd1);
        chk("ovf_hold_start latency", 64'(k), 64'd2);
        bus.Start = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_hold_start idle", {bus.Busy, bus.Done, bus.Overflow}, 3'b001);

        // Mid-run reset abandons the operation.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.OpLcm = 1'b0;
        bus.SrcA  = 32'd1;
        bus.SrcB  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        chk("midreset busy", 64'(bus.Busy), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset outputs", {bus.Busy, bus.Done, bus.Overflow, bus.Result}, 35'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        done_seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.Done || bus.Busy) done_seen = 1'b1;
        end
        chk("midreset no_done", 64'(done_seen), 64'd0);
        check_op("after_reset gcd77", 1'b0, 32'd7, 32'd7, 32'd7, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = op ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 300));
            b  = op ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 300));
            if ($urandom_range(0, 9) == 0) a = 32'd0;
            model(op, a, b, r, o, l);
            check_op($sformatf("rand%0d %s(%0d,%0d)", i, op ? "lcm" : "gcd", a, b), op, a, b, r, o, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
